// File: rtl/ahb_arbiter.sv
// Round-robin AHB-Lite arbiter: one-hot grants, address/data-phase owner tracking,
// and grant hold across fixed-length bursts and locked sequences.
module ahb_arbiter #(
  parameter int NO_OF_MANAGERS    = 4,
  parameter int BITS_FOR_MANAGERS = $clog2(NO_OF_MANAGERS),
  parameter int DEFAULT_MANAGER   = 0
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic [NO_OF_MANAGERS-1:0]    HBUSREQ,
  input  logic [NO_OF_MANAGERS-1:0]    HLOCK,
  input  logic [1:0]                   HTRANS,
  input  logic [2:0]                   HBURST,
  input  logic                         HREADY,
  output logic [NO_OF_MANAGERS-1:0]    HGRANT,
  output logic [BITS_FOR_MANAGERS-1:0] HMASTER,
  output logic [BITS_FOR_MANAGERS-1:0] HMASTER_D,
  output logic                         HMASTLOCK
);

  localparam logic [1:0] TRANS_IDLE   = 2'd0;
  localparam logic [1:0] TRANS_BUSY   = 2'd1;
  localparam logic [1:0] TRANS_NONSEQ = 2'd2;
  localparam logic [1:0] TRANS_SEQ    = 2'd3;

  localparam logic [BITS_FOR_MANAGERS-1:0] DEF_IDX =
    BITS_FOR_MANAGERS'(DEFAULT_MANAGER);
  localparam logic [BITS_FOR_MANAGERS-1:0] PTR_RST =
    BITS_FOR_MANAGERS'((DEFAULT_MANAGER + 1) % NO_OF_MANAGERS);

  function automatic logic [3:0] sat_dec(input logic [3:0] v);
    return (v == 4'd0) ? 4'd0 : v - 4'd1;
  endfunction

  // Remaining beats after the NONSEQ beat of a fixed-length burst.
  function automatic logic [3:0] burst_beats(input logic [2:0] burst);
    case (burst)
      3'd2, 3'd3: return 4'd3;
      3'd4, 3'd5: return 4'd7;
      3'd6, 3'd7: return 4'd15;
      default:    return 4'd0;
    endcase
  endfunction

  function automatic logic [NO_OF_MANAGERS-1:0] onehot(
    input logic [BITS_FOR_MANAGERS-1:0] idx);
    logic [NO_OF_MANAGERS-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  function automatic logic [BITS_FOR_MANAGERS-1:0] wrap_inc(
    input logic [BITS_FOR_MANAGERS-1:0] idx);
    return BITS_FOR_MANAGERS'((int'(idx) + 1) % NO_OF_MANAGERS);
  endfunction

  logic [3:0]                   beat_cnt;
  logic [3:0]                   beat_nxt;
  logic [BITS_FOR_MANAGERS-1:0] gnt_idx;
  logic [BITS_FOR_MANAGERS-1:0] rr_ptr;
  logic [BITS_FOR_MANAGERS-1:0] win_idx;
  logic                         win_found;
  logic                         hold;

  // Stage p0: combinational beat tracking, hold decision and round-robin scan.
  always_comb begin
    beat_nxt = beat_cnt;
    if (HREADY) begin
      case (HTRANS)
        TRANS_NONSEQ: beat_nxt = burst_beats(HBURST);
        TRANS_SEQ:    beat_nxt = sat_dec(beat_cnt);
        TRANS_BUSY:   beat_nxt = beat_cnt;
        TRANS_IDLE:   beat_nxt = 4'd0;
        default:      beat_nxt = beat_cnt;
      endcase
    end
  end

  assign hold = (beat_nxt != 4'd0) || HLOCK[HMASTER];

  always_comb begin
    logic [BITS_FOR_MANAGERS-1:0] cand;
    win_found = 1'b0;
    win_idx   = DEF_IDX;
    cand      = rr_ptr;
    for (int i = 0; i < NO_OF_MANAGERS; i++) begin
      if (!win_found && HBUSREQ[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  // Stage p1: registered grant, ownership and lock, all frozen while HREADY is low.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      beat_cnt  <= 4'd0;
      gnt_idx   <= DEF_IDX;
      HGRANT    <= onehot(DEF_IDX);
      HMASTER   <= DEF_IDX;
      HMASTER_D <= DEF_IDX;
      HMASTLOCK <= 1'b0;
      rr_ptr    <= PTR_RST;
    end else if (HREADY) begin
      beat_cnt  <= beat_nxt;
      HMASTER   <= gnt_idx;
      HMASTER_D <= HMASTER;
      HMASTLOCK <= HLOCK[gnt_idx];
      if (!hold) begin
        if (win_found) begin
          gnt_idx <= win_idx;
          HGRANT  <= onehot(win_idx);
          rr_ptr  <= wrap_inc(win_idx);
        end else begin
          gnt_idx <= DEF_IDX;
          HGRANT  <= onehot(DEF_IDX);
        end
      end
    end
  end

endmodule

// File: doc/ahb_arbiter.md
Name: ahb_arbiter

Overview:
- Round-robin bus arbiter that shares the single AHB-Lite address/data path (decoder, subordinates, response mux) between several managers.
- Samples the bus requests and issues one-hot grants.
- Tracks the current address-phase owner (HMASTER) and data-phase owner (HMASTER_D) that steer the manager-side muxes.
- Holds the grant across fixed-length bursts and locked sequences, so decoder selection is never split mid-transfer.

Parameters:
- NO_OF_MANAGERS, 4, number of requesting managers (2..8).
- BITS_FOR_MANAGERS, $clog2(NO_OF_MANAGERS), width of the manager index.
- DEFAULT_MANAGER, 0, manager parked on the bus when nobody requests.

Ports:
- HCLK  input  1  bus clock; all state updates on the rising edge.
- HRESETn  input  1  asynchronous active-low reset.
- HBUSREQ  input  NO_OF_MANAGERS  per-manager bus request, level.
- HLOCK  input  NO_OF_MANAGERS  per-manager lock request.
- HTRANS  input  2  muxed HTRANS of the current owner (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3).
- HBURST  input  3  muxed HBURST of the current owner.
- HREADY  input  1  bus-level HREADY from the response mux.
- HGRANT  output  NO_OF_MANAGERS  one-hot grant, registered.
- HMASTER  output  BITS_FOR_MANAGERS  address-phase owner index, registered.
- HMASTER_D  output  BITS_FOR_MANAGERS  data-phase owner index, registered.
- HMASTLOCK  output  1  locked-transfer indication, aligned with the address phase.

Behaviour:
- Reset (async, HRESETn=0):
  - HGRANT = one-hot(DEFAULT_MANAGER); HMASTER = HMASTER_D = DEFAULT_MANAGER.
  - HMASTLOCK=0; beat counter R=0; round-robin pointer P = DEFAULT_MANAGER+1 mod N.
  - Release is clean on the next HCLK edge.
- Beat counter R (remaining beats of the current fixed burst), updated only when HREADY=1:
  - NONSEQ with INCR4/WRAP4 → R=3; INCR8/WRAP8 → R=7; INCR16/WRAP16 → R=15.
  - NONSEQ with SINGLE/INCR → R=0.
  - SEQ → R = R-1, saturating at 0. BUSY → R unchanged. IDLE → R=0 (early termination, e.g. after ERROR).
  - Let R_next be the value R takes at this edge.
- Hold condition: hold = (R_next != 0) or HLOCK[HMASTER]==1.
- Arbitration point: HREADY=1 and hold=0. At that edge:
  - HGRANT moves to the first requester found scanning P, P+1, … mod N.
  - If nobody requests: grant DEFAULT_MANAGER.
  - If the winner equals the current grantee, HGRANT is unchanged.
  - P becomes winner+1 mod N only when a requester won; parking does not move P.
- Otherwise HGRANT holds.
- Ownership handover:
  - On every HREADY=1 edge: HMASTER ← index(HGRANT) and HMASTER_D ← HMASTER, sampled before this edge's updates.
  - HREADY=0 freezes HGRANT, HMASTER, HMASTER_D, HMASTLOCK and R.
  - Net latency from the final beat accepted to the new manager's NONSEQ on the bus is 2 HREADY edges. Grant change at edge k, ownership at edge k+1.
  - During the gap the old owner drives IDLE.
- HMASTLOCK ← HLOCK[index(HGRANT)] on each HREADY=1 edge, so it tracks the address phase of HMASTER.
- Undefined-length INCR is not held; re-arbitration may occur on any beat (permitted early termination).
- Simultaneous requests: resolved by the P rotation only; no fixed priority except for parking.
- Request drop during a held burst: ignored until the hold clears.
- Request of the current owner is not required for continued ownership.

Test Plan:
- Reset then idle, all HBUSREQ=0: HGRANT=0001, HMASTER=HMASTER_D=0, HMASTLOCK=0, steady for 10 cycles with HREADY=1.
- HBUSREQ=0110, HTRANS=IDLE, HREADY=1:
  - HGRANT=0010 at edge 1, HMASTER=1 at edge 2, HMASTER_D=1 at edge 3.
  - Manager 1 then drops its request → next grant is 0100.
- Manager 1 issues INCR4 (NONSEQ then 3×SEQ) with HBUSREQ=0011 throughout, one BUSY inserted after beat 2:
  - HGRANT stays 0010 until the edge accepting the 4th beat, then becomes 0001.
- Same INCR4 with HREADY=0 for 3 cycles on beat 3: R, HGRANT and HMASTER frozen; grant changes only after the final SEQ is accepted.
- Manager 2 with HLOCK=1 and HBUSREQ=1111 performs 3 SINGLE transfers:
  - HGRANT=0100 and HMASTLOCK=1 for the locked transfers.
  - After HLOCK drops, the grant passes to manager 3 (P=3).
- WRAP8 terminated by IDLE after beat 3 (ERROR case): R clears to 0, re-arbitration at that edge, no hold continuing.
